// File: rtl/hash_round_ctrl_param.sv
// Control FSM for the iterative hash core: word intake, absorb rounds,
// finalisation rounds and digest hand-off to the consumer.
module hash_round_ctrl_param #(
   parameter int STEPS        = 8,
   parameter int ROUNDS       = 12,
   parameter int FINAL_ROUNDS = 12,
   localparam int MAX_R   = (ROUNDS > FINAL_ROUNDS) ? ROUNDS : FINAL_ROUNDS,
   localparam int STEP_W  = (STEPS > 1) ? $clog2(STEPS) : 1,
   localparam int ROUND_W = (MAX_R > 1) ? $clog2(MAX_R) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               F_dr,
   input  logic               End_Of_File,
   input  logic               H_ack,
   output logic               F_rtr,
   output logic               validate_input,
   output logic               switch_operation,
   output logic               validate_R_H,
   output logic [STEP_W-1:0]  R_i,
   output logic [ROUND_W-1:0] R_r,
   output logic               busy,
   output logic               H_ready,
   output logic               start_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_t;

   localparam logic [STEP_W-1:0]  LAST_I = STEP_W'(STEPS - 1);
   localparam logic [ROUND_W-1:0] LAST_R = ROUND_W'(ROUNDS - 1);
   localparam logic [ROUND_W-1:0] LAST_F = ROUND_W'(FINAL_ROUNDS - 1);

   state_t             r_state;
   state_t             w_state_n;
   logic [STEP_W-1:0]  r_i;
   logic [STEP_W-1:0]  w_i_n;
   logic [ROUND_W-1:0] r_r;
   logic [ROUND_W-1:0] w_r_n;
   logic               r_last;
   logic               w_last_n;
   logic               r_serr;
   logic               w_step_end;
   logic               w_round_end;
   logic               w_final_end;
   logic [STEP_W-1:0]  w_i_inc;
   logic [ROUND_W-1:0] w_r_inc;

   assign w_step_end  = (r_i == LAST_I);
   assign w_round_end = w_step_end && (r_r == LAST_R);
   assign w_final_end = w_step_end && (r_r == LAST_F);
   assign w_i_inc     = r_i + 1'b1;
   assign w_r_inc     = r_r + 1'b1;

   always_comb begin
      w_state_n        = r_state;
      w_i_n            = r_i;
      w_r_n            = r_r;
      w_last_n         = r_last;
      F_rtr            = 1'b0;
      switch_operation = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start) w_state_n = S_WAIT;
         end
         S_WAIT: begin
            F_rtr = 1'b1;
            if (F_dr) begin
               w_last_n  = End_Of_File;
               w_state_n = S_ROUND;
            end else if (End_Of_File) begin
               switch_operation = 1'b1;
               w_state_n        = S_FINAL;
            end
         end
         S_ROUND: begin
            if (w_round_end) begin
               w_i_n = '0;
               w_r_n = '0;
               if (r_last) begin
                  switch_operation = 1'b1;
                  w_state_n        = S_FINAL;
               end else begin
                  w_state_n = S_WAIT;
               end
            end else if (w_step_end) begin
               w_i_n = '0;
               w_r_n = w_r_inc;
            end else begin
               w_i_n = w_i_inc;
            end
         end
         S_FINAL: begin
            if (w_final_end) begin
               w_i_n     = '0;
               w_r_n     = '0;
               w_state_n = S_DONE;
            end else if (w_step_end) begin
               w_i_n = '0;
               w_r_n = w_r_inc;
            end else begin
               w_i_n = w_i_inc;
            end
         end
         S_DONE: begin
            if (H_ack) w_state_n = S_IDLE;
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase
      // abort overrides every normal transition, including start in IDLE
      if (abort) begin
         w_state_n = S_IDLE;
         w_i_n     = '0;
         w_r_n     = '0;
         w_last_n  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_r     <= '0;
         r_last  <= 1'b0;
         r_serr  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_i     <= w_i_n;
         r_r     <= w_r_n;
         r_last  <= w_last_n;
         r_serr  <= start && !abort && (r_state != S_IDLE);
      end
   end

   assign validate_input = F_dr && F_rtr;
   assign validate_R_H   = validate_input || switch_operation;
   assign R_i            = r_i;
   assign R_r            = r_r;
   assign busy           = (r_state != S_IDLE);
   assign H_ready        = (r_state == S_DONE);
   assign start_err      = r_serr;

endmodule

// File: tb/tb_hash_round_ctrl_param.sv
// Bench for hash_round_ctrl_param: directed latency scenarios on a default
// and a small instance, then random traffic against a phase/elapsed model.
module tb_hash_round_ctrl_param;

   localparam int PS [2] = '{8, 4};
   localparam int PR [2] = '{12, 10};
   localparam int PF [2] = '{12, 2};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] start, abort, fdr, eof, hack;
   logic [1:0] rtr, vi, so, vrh, busy, hr, serr;
   logic [2:0] ri_a;
   logic [3:0] rr_a;
   logic [1:0] ri_b;
   logic [3:0] rr_b;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   int so_t [2];
   int acc_n [2];
   int t0;

   // model: mode 0 idle, 1 wait, 2 absorb, 3 final, 4 done
   int m_mode [2];
   int m_t [2];
   bit m_last [2];
   bit m_serr [2];

   always #5 clk = ~clk;

   hash_round_ctrl_param u_a (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
      .F_dr(fdr[0]), .End_Of_File(eof[0]), .H_ack(hack[0]),
      .F_rtr(rtr[0]), .validate_input(vi[0]),
      .switch_operation(so[0]), .validate_R_H(vrh[0]),
      .R_i(ri_a), .R_r(rr_a), .busy(busy[0]), .H_ready(hr[0]),
      .start_err(serr[0])
   );

   hash_round_ctrl_param #(
      .STEPS(4), .ROUNDS(10), .FINAL_ROUNDS(2)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
      .F_dr(fdr[1]), .End_Of_File(eof[1]), .H_ack(hack[1]),
      .F_rtr(rtr[1]), .validate_input(vi[1]),
      .switch_operation(so[1]), .validate_R_H(vrh[1]),
      .R_i(ri_b), .R_r(rr_b), .busy(busy[1]), .H_ready(hr[1]),
      .start_err(serr[1])
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(int k);
      bit nserr;
      nserr = (m_mode[k] != 0) && start[k] && !abort[k];
      if (!rst_n || abort[k]) begin
         m_mode[k] = 0;
         m_t[k]    = 0;
         m_last[k] = 0;
         m_serr[k] = 0;
      end else begin
         m_serr[k] = nserr;
         case (m_mode[k])
            0: if (start[k]) m_mode[k] = 1;
            1: begin
               if (fdr[k]) begin
                  m_last[k] = eof[k];
                  m_mode[k] = 2;
                  m_t[k]    = 0;
               end else if (eof[k]) begin
                  m_mode[k] = 3;
                  m_t[k]    = 0;
               end
            end
            2: begin
               if (m_t[k] == PS[k] * PR[k] - 1) begin
                  m_t[k]    = 0;
                  m_mode[k] = m_last[k] ? 3 : 1;
               end else m_t[k]++;
            end
            3: begin
               if (m_t[k] == PS[k] * PF[k] - 1) begin
                  m_t[k]    = 0;
                  m_mode[k] = 4;
               end else m_t[k]++;
            end
            default: if (hack[k]) m_mode[k] = 0;
         endcase
      end
   endtask

   // check every output of both instances, advance the model, move one cycle
   task automatic cyc();
      #1;
      for (int k = 0; k < 2; k++) begin
         bit act, xso, xvi;
         int xri, xrr;
         act = (m_mode[k] == 2) || (m_mode[k] == 3);
         xvi = (m_mode[k] == 1) && fdr[k];
         xso = ((m_mode[k] == 1) && !fdr[k] && eof[k]) ||
               ((m_mode[k] == 2) && m_last[k] &&
                (m_t[k] == PS[k] * PR[k] - 1));
         xri = act ? m_t[k] % PS[k] : 0;
         xrr = act ? m_t[k] / PS[k] : 0;
         chk($sformatf("rtr%0d", k), rtr[k], m_mode[k] == 1);
         chk($sformatf("vi%0d", k), vi[k], xvi);
         chk($sformatf("so%0d", k), so[k], xso);
         chk($sformatf("vrh%0d", k), vrh[k], xvi | xso);
         chk($sformatf("ri%0d", k), k ? 32'(ri_b) : 32'(ri_a), xri);
         chk($sformatf("rr%0d", k), k ? 32'(rr_b) : 32'(rr_a), xrr);
         chk($sformatf("busy%0d", k), busy[k], m_mode[k] != 0);
         chk($sformatf("hr%0d", k), hr[k], m_mode[k] == 4);
         chk($sformatf("serr%0d", k), serr[k], m_serr[k]);
         if (so[k] === 1'b1) so_t[k] = cyc_n;
         if (vi[k] === 1'b1) acc_n[k]++;
         model_step(k);
      end
      @(posedge clk);
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic wait_hr(int k, int max);
      int n;
      n = 0;
      while (hr[k] !== 1'b1 && n < max) begin
         cyc();
         n++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = '0; abort = '0; fdr = '0; eof = '0; hack = '0;
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_t[k] = 0; m_last[k] = 0; m_serr[k] = 0;
         so_t[k] = -1; acc_n[k] = 0;
      end
      @(negedge clk);
      cyc();
      rst_n = 1'b1;
      cyc();

      // reset in the middle of an absorb round
      start[0] = 1; cyc(); start[0] = 0;
      fdr[0] = 1; cyc(); fdr[0] = 0;
      repeat (43) cyc();
      chk("t1_ri_mid", ri_a, 3);
      chk("t1_rr_mid", rr_a, 5);
      rst_n = 0; cyc(); rst_n = 1;
      chk("t1_busy", busy[0], 0);
      chk("t1_ri", ri_a, 0);
      chk("t1_rr", rr_a, 0);
      chk("t1_hr", hr[0], 0);
      cyc();

      // single word carrying EOF
      start[0] = 1; cyc(); start[0] = 0;
      acc_n[0] = 0; so_t[0] = -1;
      fdr[0] = 1; eof[0] = 1; t0 = cyc_n; cyc();
      fdr[0] = 0; eof[0] = 0;
      wait_hr(0, 400);
      chk("t2_hready_lat", cyc_n - t0, 193);
      chk("t2_switch_lat", so_t[0] - t0, 96);
      chk("t2_accepts", acc_n[0], 1);
      repeat (3) cyc();
      chk("t2_hready_held", hr[0], 1);
      hack[0] = 1; cyc(); hack[0] = 0;
      chk("t2_idle_after_ack", busy[0], 0);

      // two words with F_dr held high the whole time
      start[0] = 1; cyc(); start[0] = 0;
      acc_n[0] = 0;
      fdr[0] = 1; t0 = cyc_n; cyc();
      repeat (96) cyc();
      chk("t3_rtr_second", rtr[0], 1);
      eof[0] = 1; cyc();
      fdr[0] = 0; eof[0] = 0;
      wait_hr(0, 400);
      chk("t3_hready_lat", cyc_n - t0, 290);
      chk("t3_accepts", acc_n[0], 2);
      hack[0] = 1; cyc(); hack[0] = 0;

      // empty message
      start[0] = 1; cyc(); start[0] = 0;
      acc_n[0] = 0; so_t[0] = -1;
      eof[0] = 1; t0 = cyc_n; cyc(); eof[0] = 0;
      chk("t4_switch_at_T", so_t[0] - t0, 0);
      wait_hr(0, 200);
      chk("t4_hready_lat", cyc_n - t0, 97);
      chk("t4_accepts", acc_n[0], 0);
      hack[0] = 1; cyc(); hack[0] = 0;

      // abort with start mid-round, then start while busy
      start[0] = 1; cyc(); start[0] = 0;
      fdr[0] = 1; cyc(); fdr[0] = 0;
      repeat (43) cyc();
      abort[0] = 1; start[0] = 1; cyc(); abort[0] = 0; start[0] = 0;
      chk("t5_abort_busy", busy[0], 0);
      chk("t5_abort_ri", ri_a, 0);
      chk("t5_abort_rr", rr_a, 0);
      chk("t5_no_serr", serr[0], 0);
      start[0] = 1; cyc(); cyc(); start[0] = 0;
      chk("t5_serr_pulse", serr[0], 1);
      chk("t5_still_busy", busy[0], 1);
      cyc();
      chk("t5_serr_once", serr[0], 0);
      chk("t5_still_wait", rtr[0], 1);
      abort[0] = 1; cyc(); abort[0] = 0;

      // small instance: STEPS=4 ROUNDS=10 FINAL_ROUNDS=2
      start[1] = 1; cyc(); start[1] = 0;
      so_t[1] = -1;
      fdr[1] = 1; eof[1] = 1; t0 = cyc_n; cyc();
      fdr[1] = 0; eof[1] = 0;
      wait_hr(1, 200);
      chk("t6_hready_lat", cyc_n - t0, 49);
      chk("t6_switch_lat", so_t[1] - t0, 40);
      hack[1] = 1; cyc(); hack[1] = 0;

      // random traffic on both instances
      repeat (3000) begin
         rst_n = ($urandom_range(0, 299) != 0);
         for (int k = 0; k < 2; k++) begin
            start[k] = ($urandom_range(0, 3) == 0);
            abort[k] = ($urandom_range(0, 99) == 0);
            fdr[k]   = ($urandom_range(0, 2) == 0);
            eof[k]   = ($urandom_range(0, 3) == 0);
            hack[k]  = ($urandom_range(0, 3) == 0);
         end
         cyc();
      end
      rst_n = 1; start = '0; abort = '0; fdr = '0; eof = '0; hack = '0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
